ihex_dump_sched: RTL and testbench

//  Shares one single-port synchronous byte RAM between the Intel-HEX decoder write stream and a
//  hex-dump sequencer, and sequences the dump onto uart_tx. Sits between ihex_decoder, the RAM
//  and uart_tx. On start, the whole RAM is read and emitted as lowercase hex pairs, each followed
//  by a separator: ' ' or '\n' at end of line.

---
 rtl/ihex_dump_sched.sv | 162 ++++++++++++++++
 tb/tb_ihex_dump_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ihex_dump_sched.sv
// Shares one single-port byte RAM between decoder writes and a hex-dump reader (round-robin),
// and streams the whole RAM as lowercase hex pairs plus ' '/'\n' separators onto uart_tx.
module ihex_dump_sched #(
    parameter int ADDR_W    = 8,
    parameter int LINE_LOG2 = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_req,
    input  logic              tx_sendable,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HI,
        S_LO,
        S_SEP
    } state_t;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        byte_q, byte_d;
    logic              done_q, done_d;

    logic rd_req;
    logic grant_rd;
    logic grant_wr;
    logic tx_accept;
    logic line_end;
    logic last_addr;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Reads are only wanted in FETCH; on contention the side not served last time wins.
    // Grants are suppressed while reset is high so a pending write is never acknowledged.
    always_comb begin
        rd_req   = (state_q == S_FETCH);
        grant_rd = !reset && rd_req && (!wr_req || (last_grant_q == GRANT_WRITE));
        grant_wr = !reset && wr_req && !grant_rd;
    end

    assign wr_ack    = grant_wr;
    assign mem_en    = grant_rd | grant_wr;
    assign mem_we    = grant_wr;
    assign mem_addr  = grant_wr ? wr_addr : (grant_rd ? addr_q : '0);
    assign mem_wdata = grant_wr ? wr_data : 8'h00;

    assign line_end  = &addr_q[LINE_LOG2-1:0];
    assign last_addr = &addr_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign tx_accept = tx_req & tx_sendable;

    // NOTE: every output of a combinational block gets a default before the case, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        tx_req  = 1'b0;
        tx_data = 8'h00;
        case (state_q)
            S_HI: begin
                tx_req  = 1'b1;
                tx_data = hex_char(byte_q[7:4]);
            end
            S_LO: begin
                tx_req  = 1'b1;
                tx_data = hex_char(byte_q[3:0]);
            end
            S_SEP: begin
                tx_req  = 1'b1;
                tx_data = line_end ? 8'h0A : 8'h20;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        byte_d       = byte_q;
        done_d       = 1'b0;
        last_grant_d = last_grant_q;

        if (grant_rd) begin
            last_grant_d = GRANT_READ;
        end else if (grant_wr) begin
            last_grant_d = GRANT_WRITE;
        end

        case (state_q)
            S_IDLE: ;
            S_FETCH: if (grant_rd) state_d = S_WAIT;
            S_WAIT: begin
                byte_d  = mem_rdata;
                state_d = S_HI;
            end
            S_HI: if (tx_accept) state_d = S_LO;
            S_LO: if (tx_accept) state_d = S_SEP;
            S_SEP: begin
                if (tx_accept) begin
                    if (last_addr) begin
                        state_d = S_IDLE;
                        addr_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A restart overrides whatever the current state decided, including a final done.
        if (start) begin
            state_d = S_FETCH;
            addr_d  = '0;
            done_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            byte_q       <= 8'h00;
            done_q       <= 1'b0;
            last_grant_q <= GRANT_WRITE;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            byte_q       <= byte_d;
            done_q       <= done_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_ihex_dump_sched.sv
// Directed bench for ihex_dump_sched: drives a RAM model and a uart stand-in, checks the
// character stream, arbitration, stalls, restart and reset against hand-computed values.
module tb_ihex_dump_sched;

    localparam int DEPTH  = 256;
    localparam int NCHARS = 768;

    logic       clock = 1'b0;
    logic       reset, start, wr_req, tx_sendable;
    logic [7:0] wr_addr, wr_data;
    logic       wr_ack, mem_en, mem_we, tx_req, busy, done;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, tx_data;

    always #5 clock = ~clock;

    ihex_dump_sched #(.ADDR_W(8), .LINE_LOG2(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .tx_sendable(tx_sendable),
        .busy       (busy),
        .done       (done)
    );

    // Synchronous single-port RAM with a bench-side fill/poke path used only while idle.
    logic [7:0] ram [DEPTH];
    logic       bd_fill, bd_en;
    logic [7:0] bd_addr, bd_data;

    always @(posedge clock) begin
        if (bd_fill) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 8'(i);
        end else if (bd_en) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    logic [7:0] exp_mem [DEPTH];
    logic [7:0] chars [$];
    int done_cnt = 0, done_busy_cnt = 0, viol_cnt = 0, wr_busy_cnt = 0, rd_busy_cnt = 0;
    logic prev_unacked = 1'b0, prev_rd = 1'b0;

    always @(negedge clock) begin
        if (tx_req && tx_sendable && !reset) chars.push_back(tx_data);
        if (done) begin
            done_cnt++;
            if (busy) done_busy_cnt++;
        end
        if (!reset) begin
            if (wr_ack !== (mem_en && mem_we)) viol_cnt++;
            if (mem_en && mem_we && (mem_addr !== wr_addr || mem_wdata !== wr_data || !wr_req))
                viol_cnt++;
            if (mem_en && !mem_we && !busy) viol_cnt++;
            if (wr_req && !wr_ack && prev_unacked) viol_cnt++;
            if (mem_en && !mem_we && prev_rd) viol_cnt++;
            if (busy && wr_ack) wr_busy_cnt++;
            if (busy && mem_en && !mem_we) rd_busy_cnt++;
            prev_unacked = wr_req && !wr_ack;
            prev_rd      = mem_en && !mem_we;
        end else begin
            prev_unacked = 1'b0;
            prev_rd      = 1'b0;
        end
    end

    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] exp_char(input int j);
        string hexd = "0123456789abcdef";
        int b = j / 3;
        logic [7:0] v = exp_mem[b];
        case (j % 3)
            0:       return hexd[int'(v[7:4])];
            1:       return hexd[int'(v[3:0])];
            default: return ((b % 16) == 15) ? 8'h0A : 8'h20;
        endcase
    endfunction

    function automatic int stream_errs(input int base);
        int errs = 0;
        for (int j = 0; j < NCHARS; j++) begin
            if (base + j >= chars.size()) errs++;
            else if (chars[base + j] !== exp_char(j)) errs++;
        end
        return errs;
    endfunction

    task automatic wait_done(input string tag, input int base, input int limit);
        int n = 0;
        while (done_cnt == base && n < limit) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(done_cnt != base), 32'd1);
        repeat (3) tick();
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_data = d;
        bd_en   = 1'b1;
        tick();
        bd_en   = 1'b0;
    endtask

    task automatic wait_read(input string tag, input logic [7:0] a);
        int  n    = 0;
        logic seen = 1'b0;
        while (!seen && n < 3000) begin
            @(negedge clock);
            seen = mem_en && !mem_we && (mem_addr == a);
            n++;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int base_c, base_d, base_wr, base_rd, base_v, n_pre, n;
    logic acked;

    initial begin
        reset = 1'b1; start = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
        tx_sendable = 1'b1; bd_fill = 1'b0; bd_en = 1'b0; bd_addr = 8'h00; bd_data = 8'h00;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'(i);
        bd_fill = 1'b1;
        tick();
        bd_fill = 1'b0;

        // Reset state, with a write held to prove it is not acknowledged while reset is high.
        wr_req = 1'b1; wr_addr = 8'h55; wr_data = 8'hAA;
        tick();
        @(negedge clock);
        check("rst_tx_req", 32'(tx_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_mem_addr_wdata", {16'd0, mem_addr, mem_wdata}, 32'd0);
        wr_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Full dump with latency check.
        base_c = chars.size(); base_d = done_cnt;
        pulse_start();
        @(negedge clock);
        check("lat_fetch", {21'd0, mem_en, mem_we, tx_req, mem_addr}, {21'd0, 3'b100, 8'h00});
        @(negedge clock);
        check("lat_wait", 32'(tx_req), 32'd0);
        @(negedge clock);
        check("lat_hi", {23'd0, tx_req, tx_data}, {23'd0, 1'b1, 8'h30});
        wait_done("d1_done_seen", base_d, 3000);
        check("d1_done_once", 32'(done_cnt - base_d), 32'd1);
        check("d1_len", 32'(chars.size() - base_c), 32'd768);
        check("d1_stream", 32'(stream_errs(base_c)), 32'd0);
        check("d1_nl_line0", 32'(chars[base_c + 47]), 32'h0A);
        check("d1_last_f", 32'(chars[base_c + 765]), 32'h66);
        check("d1_last_nl", 32'(chars[base_c + 767]), 32'h0A);

        // Continuous writes (rewriting each address with its own value) during a dump.
        base_c = chars.size(); base_d = done_cnt;
        base_wr = wr_busy_cnt; base_rd = rd_busy_cnt; base_v = viol_cnt;
        wr_req = 1'b1; wr_addr = 8'h00; wr_data = 8'h00;
        pulse_start();
        n = 0;
        while (done_cnt == base_d && n < 3000) begin
            @(negedge clock);
            acked = wr_ack;
            tick();
            if (acked) begin
                wr_addr = wr_addr + 8'd1;
                wr_data = wr_addr;
            end
            n++;
        end
        wr_req = 1'b0;
        check("d2_done_seen", 32'(done_cnt != base_d), 32'd1);
        repeat (3) tick();
        check("d2_writes_in_dump", 32'(wr_busy_cnt - base_wr), 32'd1024);
        check("d2_reads_in_dump", 32'(rd_busy_cnt - base_rd), 32'd256);
        check("d2_arb_violations", 32'(viol_cnt - base_v), 32'd0);
        check("d2_len", 32'(chars.size() - base_c), 32'd768);
        check("d2_stream", 32'(stream_errs(base_c)), 32'd0);

        // Write to an address right after its read grant: old byte dumped, new one next time.
        poke(8'h10, 8'hA5);
        exp_mem[8'h10] = 8'hA5;
        base_c = chars.size(); base_d = done_cnt;
        pulse_start();
        wait_read("d3_read10_seen", 8'h10);
        tick();
        wr_req = 1'b1; wr_addr = 8'h10; wr_data = 8'h3C;
        @(negedge clock);
        check("d3_wr_ack_in_wait", 32'(wr_ack), 32'd1);
        tick();
        wr_req = 1'b0;
        wait_done("d3_done_seen", base_d, 3000);
        check("d3_old_byte", {16'd0, chars[base_c + 48], chars[base_c + 49]}, 32'h6135);
        check("d3_stream", 32'(stream_errs(base_c)), 32'd0);
        exp_mem[8'h10] = 8'h3C;
        base_c = chars.size(); base_d = done_cnt;
        pulse_start();
        wait_done("d3b_done_seen", base_d, 3000);
        check("d3b_new_byte", {16'd0, chars[base_c + 48], chars[base_c + 49]}, 32'h3363);
        check("d3b_stream", 32'(stream_errs(base_c)), 32'd0);

        // Back-pressure: hold HI, then stall LO for 5 cycles.
        poke(8'h00, 8'h7E);
        exp_mem[0] = 8'h7E;
        base_c = chars.size(); base_d = done_cnt;
        tx_sendable = 1'b0;
        pulse_start();
        tick();
        tick();
        @(negedge clock);
        check("d4_hi_held", {23'd0, tx_req, tx_data}, {23'd0, 1'b1, 8'h37});
        tx_sendable = 1'b1;
        tick();
        tx_sendable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("d4_lo_stall", {23'd0, tx_req, tx_data}, {23'd0, 1'b1, 8'h65});
        end
        tx_sendable = 1'b1;
        wait_done("d4_done_seen", base_d, 3000);
        check("d4_len", 32'(chars.size() - base_c), 32'd768);
        check("d4_stream", 32'(stream_errs(base_c)), 32'd0);

        // Restart mid-line while the high nibble of byte 0x23 is being accepted.
        base_c = chars.size(); base_d = done_cnt;
        pulse_start();
        wait_read("d5_read23_seen", 8'h23);
        tick();
        tick();
        pulse_start();
        @(negedge clock);
        check("d5_refetch_addr0", {22'd0, mem_en, mem_we, mem_addr}, {22'd0, 2'b10, 8'h00});
        n_pre = chars.size();
        check("d5_chars_before", 32'(n_pre - base_c), 32'd106);
        check("d5_last_before", 32'(chars[n_pre - 1]), 32'h32);
        check("d5_no_done_yet", 32'(done_cnt - base_d), 32'd0);
        wait_done("d5_done_seen", base_d, 3000);
        check("d5_done_once", 32'(done_cnt - base_d), 32'd1);
        check("d5_first_after", 32'(chars[n_pre]), 32'h37);
        check("d5_len", 32'(chars.size() - n_pre), 32'd768);
        check("d5_stream", 32'(stream_errs(n_pre)), 32'd0);

        // Reset while in SEP with a write pending, then a clean dump.
        base_d = done_cnt;
        pulse_start();
        repeat (4) tick();
        @(negedge clock);
        check("d6_in_sep", {23'd0, tx_req, tx_data}, {23'd0, 1'b1, 8'h20});
        reset = 1'b1; wr_req = 1'b1; wr_addr = 8'h80; wr_data = 8'hEE;
        #1;
        check("d6_no_ack_in_reset", 32'(wr_ack), 32'd0);
        tick();
        @(negedge clock);
        check("d6_after_reset", {27'd0, tx_req, busy, mem_en, wr_ack, done}, 32'd0);
        reset = 1'b0; wr_req = 1'b0;
        tick();
        check("d6_no_done", 32'(done_cnt - base_d), 32'd0);
        base_c = chars.size(); base_d = done_cnt;
        pulse_start();
        wait_done("d6_done_seen", base_d, 3000);
        check("d6_first_char", 32'(chars[base_c]), 32'h37);
        check("d6_len", 32'(chars.size() - base_c), 32'd768);
        check("d6_stream", 32'(stream_errs(base_c)), 32'd0);

        check("all_arb_violations", 32'(viol_cnt), 32'd0);
        check("done_with_busy", 32'(done_busy_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
